// File: rtl/param_tensor_cpu_pkg.sv
// Shared opcodes, engine state type and instruction classification for param_tensor_cpu.
package param_tensor_cpu_pkg;

  localparam logic [7:0] OP_ADD        = 8'h00;
  localparam logic [7:0] OP_SUB        = 8'h01;
  localparam logic [7:0] OP_MUL        = 8'h02;
  localparam logic [7:0] OP_EQL        = 8'h03;
  localparam logic [7:0] OP_GRT        = 8'h04;
  localparam logic [7:0] OP_TC_OPERATE = 8'h05;
  localparam logic [7:0] OP_TC_LOAD    = 8'h06;
  localparam logic [7:0] OP_CPU_TO_TC  = 8'h07;
  localparam logic [7:0] OP_NOP        = 8'h08;
  localparam logic [7:0] OP_ADD_IMM    = 8'h09;
  localparam logic [7:0] OP_SUB_IMM    = 8'h0A;
  localparam logic [7:0] OP_MOV_CPU    = 8'h0B;
  localparam logic [7:0] OP_MOV_TC     = 8'h0C;
  localparam logic [7:0] OP_RESET      = 8'h0D;
  localparam logic [7:0] OP_TC_TO_CPU  = 8'h0E;
  localparam logic [7:0] OP_READ_CPU   = 8'h0F;
  localparam logic [7:0] OP_READ_TC    = 8'h10;

  typedef enum logic [1:0] {StIdle, StRun, StCommit} eng_state_e;

  // Opcodes that touch the tensor file and therefore stall while the engine runs.
  function automatic logic tensor_class(input logic [7:0] opcode);
    return opcode inside {OP_TC_OPERATE, OP_TC_LOAD, OP_CPU_TO_TC, OP_MOV_TC, OP_TC_TO_CPU,
                          OP_READ_TC};
  endfunction

endpackage

// File: rtl/param_tensor_cpu_if.sv
// Instruction valid/ready handshake between an instruction source and param_tensor_cpu.
interface param_tensor_cpu_if;
  logic [31:0] instruction_in;
  logic        instruction_valid_in;
  logic        instruction_ready_out;

  modport master (
    output instruction_in,
    output instruction_valid_in,
    input  instruction_ready_out
  );

  modport slave (
    input  instruction_in,
    input  instruction_valid_in,
    output instruction_ready_out
  );
endinterface

// File: rtl/param_tensor_cpu_tensor_mac_engine.sv
// Sequential N x N matrix multiplier: one MAC per cycle into a result buffer, then a
// single-cycle commit strobe for the owner to copy the buffer into bank A.
module tensor_mac_engine
  import param_tensor_cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MATRIX_DIM = 4,
  parameter int unsigned SATURATE   = 0
) (
  input  logic                                          clock_in,
  input  logic                                          reset_n_in,
  input  logic                                          start_in,
  input  logic                                          abort_in,
  input  logic [MATRIX_DIM*MATRIX_DIM*DATA_WIDTH-1:0]   bank_a_in,
  input  logic [MATRIX_DIM*MATRIX_DIM*DATA_WIDTH-1:0]   bank_b_in,
  output logic                                          busy_out,
  output logic                                          commit_out,
  output logic [MATRIX_DIM*MATRIX_DIM*DATA_WIDTH-1:0]   result_out
);

  localparam int unsigned N     = MATRIX_DIM;
  localparam int unsigned IDX_W = $clog2(N);
  localparam int unsigned ACC_W = 2 * DATA_WIDTH + $clog2(N);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  eng_state_e state_q;
  logic [IDX_W-1:0] i_q, j_q, k_q;
  logic signed [ACC_W-1:0] acc_q, acc_next;
  logic busy_q, commit_q;
  logic [DATA_WIDTH-1:0] a_mat [N][N];
  logic [DATA_WIDTH-1:0] b_mat [N][N];
  logic [DATA_WIDTH-1:0] buf_q [N][N];
  logic [2*DATA_WIDTH-1:0] a_ext, b_ext, prod;
  logic [DATA_WIDTH-1:0] c_val;

  always_comb begin
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        a_mat[r][c] = bank_a_in[(r*N + c)*DATA_WIDTH +: DATA_WIDTH];
        b_mat[r][c] = bank_b_in[(r*N + c)*DATA_WIDTH +: DATA_WIDTH];
        result_out[(r*N + c)*DATA_WIDTH +: DATA_WIDTH] = buf_q[r][c];
      end
    end
  end

  always_comb begin
    a_ext = {{DATA_WIDTH{a_mat[i_q][k_q][DATA_WIDTH-1]}}, a_mat[i_q][k_q]};
    b_ext = {{DATA_WIDTH{b_mat[k_q][j_q][DATA_WIDTH-1]}}, b_mat[k_q][j_q]};
    prod = a_ext * b_ext;
    acc_next = acc_q + {{(ACC_W - 2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
    c_val = acc_next[DATA_WIDTH-1:0];
    if (SATURATE != 0) begin
      if (acc_next > SAT_MAX) c_val = SAT_MAX[DATA_WIDTH-1:0];
      else if (acc_next < SAT_MIN) c_val = SAT_MIN[DATA_WIDTH-1:0];
    end
  end

  // Walk order: k innermost, then j, then i.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q  <= StIdle;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      commit_q <= 1'b0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) buf_q[r][c] <= '0;
      end
    end else if (abort_in) begin
      state_q  <= StIdle;
      busy_q   <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_in) begin
            state_q <= StRun;
            busy_q  <= 1'b1;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
          end
        end
        StRun: begin
          if (k_q == LAST) begin
            buf_q[i_q][j_q] <= c_val;
            acc_q <= '0;
            k_q   <= '0;
            if (j_q == LAST) begin
              j_q <= '0;
              if (i_q == LAST) begin
                i_q      <= '0;
                state_q  <= StCommit;
                commit_q <= 1'b1;
              end else begin
                i_q <= i_q + 1'b1;
              end
            end else begin
              j_q <= j_q + 1'b1;
            end
          end else begin
            acc_q <= acc_next;
            k_q   <= k_q + 1'b1;
          end
        end
        StCommit: begin
          state_q  <= StIdle;
          busy_q   <= 1'b0;
          commit_q <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_out   = busy_q;
  assign commit_out = commit_q;

endmodule

// File: rtl/param_tensor_cpu.sv
// Parametrised CPU with inline register/tensor files and an attached sequential MAC engine.
module param_tensor_cpu
  import param_tensor_cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned MATRIX_DIM = 4,
  parameter int unsigned SATURATE   = 0
) (
  input  logic                  clock_in,
  input  logic                  reset_n_in,
  param_tensor_cpu_if.slave     instr_if,
  output logic [DATA_WIDTH-1:0] cpu_output_out,
  output logic                  cpu_output_valid_out,
  output logic [4:0]            status_out,
  output logic                  tensor_busy_out
);

  localparam int unsigned N         = MATRIX_DIM;
  localparam int unsigned BANK      = N * N;
  localparam int unsigned T_ENTRIES = 2 * BANK;
  localparam int unsigned TADDR_W   = $clog2(T_ENTRIES);
  localparam int unsigned REG_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [DATA_WIDTH-1:0] regs_q   [NUM_REGS];
  logic [DATA_WIDTH-1:0] tensor_q [T_ENTRIES];
  logic [DATA_WIDTH-1:0] out_q;
  logic                  out_valid_q;
  logic [4:0]            status_q;

  logic [7:0] opcode, dest, src1, src2;
  logic       accept, eng_busy, eng_commit;
  logic       dest_ok, src1_ok, src2_ok, t_dest_ok, t_src1_ok;
  logic [TADDR_W-1:0] t_dest, t_src1;
  logic [DATA_WIDTH-1:0] r_src1, r_src2, t_src1_val, op_b, imm_lo, imm_hi;
  logic [BANK*DATA_WIDTH-1:0] bank_a, bank_b, eng_result;

  assign opcode = instr_if.instruction_in[7:0];
  assign src2   = instr_if.instruction_in[15:8];
  assign src1   = instr_if.instruction_in[23:16];
  assign dest   = instr_if.instruction_in[31:24];

  assign instr_if.instruction_ready_out = !(eng_busy && tensor_class(opcode));
  assign accept = instr_if.instruction_valid_in && instr_if.instruction_ready_out;

  assign dest_ok   = 32'(dest) < NUM_REGS;
  assign src1_ok   = 32'(src1) < NUM_REGS;
  assign src2_ok   = 32'(src2) < NUM_REGS;
  assign t_dest    = dest[TADDR_W-1:0];
  assign t_src1    = src1[TADDR_W-1:0];
  assign t_dest_ok = 32'(t_dest) < T_ENTRIES;
  assign t_src1_ok = 32'(t_src1) < T_ENTRIES;

  assign r_src1     = src1_ok ? regs_q[src1[REG_W-1:0]] : '0;
  assign r_src2     = src2_ok ? regs_q[src2[REG_W-1:0]] : '0;
  assign t_src1_val = t_src1_ok ? tensor_q[t_src1] : '0;
  assign imm_lo     = DATA_WIDTH'($signed(src2));
  assign imm_hi     = DATA_WIDTH'($signed(src1));
  assign op_b       = (opcode == OP_ADD_IMM || opcode == OP_SUB_IMM) ? imm_lo : r_src2;

  always_comb begin
    for (int t = 0; t < BANK; t++) begin
      bank_a[t*DATA_WIDTH +: DATA_WIDTH] = tensor_q[t];
      bank_b[t*DATA_WIDTH +: DATA_WIDTH] = tensor_q[BANK + t];
    end
  end

  logic [DATA_WIDTH:0]     sum_ext, diff_ext;
  logic [2*DATA_WIDTH-1:0] a_ext, b_ext, mul_full;
  logic [DATA_WIDTH-1:0]   alu_res;
  logic                    alu_carry, alu_ovf, is_alu;
  logic [4:0]              alu_status;

  always_comb begin
    a_ext     = {{DATA_WIDTH{r_src1[DATA_WIDTH-1]}}, r_src1};
    b_ext     = {{DATA_WIDTH{op_b[DATA_WIDTH-1]}}, op_b};
    sum_ext   = {1'b0, r_src1} + {1'b0, op_b};
    diff_ext  = {1'b0, r_src1} - {1'b0, op_b};
    mul_full  = a_ext * b_ext;
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    is_alu    = 1'b1;
    case (opcode)
      OP_ADD, OP_ADD_IMM: begin
        alu_res   = sum_ext[DATA_WIDTH-1:0];
        alu_carry = sum_ext[DATA_WIDTH];
        alu_ovf   = (r_src1[DATA_WIDTH-1] == op_b[DATA_WIDTH-1]) &&
                    (alu_res[DATA_WIDTH-1] != r_src1[DATA_WIDTH-1]);
      end
      OP_SUB, OP_SUB_IMM: begin
        alu_res   = diff_ext[DATA_WIDTH-1:0];
        alu_carry = diff_ext[DATA_WIDTH];
        alu_ovf   = (r_src1[DATA_WIDTH-1] != op_b[DATA_WIDTH-1]) &&
                    (alu_res[DATA_WIDTH-1] != r_src1[DATA_WIDTH-1]);
      end
      OP_MUL: begin
        alu_res = mul_full[DATA_WIDTH-1:0];
        // Product overflows when the upper half is not a sign extension of the lower half.
        alu_ovf = mul_full[2*DATA_WIDTH-1:DATA_WIDTH] != {DATA_WIDTH{alu_res[DATA_WIDTH-1]}};
      end
      OP_EQL:  alu_res = DATA_WIDTH'(r_src1 == op_b);
      OP_GRT:  alu_res = DATA_WIDTH'($signed(r_src1) > $signed(op_b));
      default: is_alu = 1'b0;
    endcase
    alu_status = {~^alu_res, alu_ovf, alu_carry, alu_res == '0, alu_res[DATA_WIDTH-1]};
  end

  tensor_mac_engine #(
    .DATA_WIDTH (DATA_WIDTH),
    .MATRIX_DIM (MATRIX_DIM),
    .SATURATE   (SATURATE)
  ) u_engine (
    .clock_in   (clock_in),
    .reset_n_in (reset_n_in),
    .start_in   (accept && opcode == OP_TC_OPERATE),
    .abort_in   (accept && opcode == OP_RESET),
    .bank_a_in  (bank_a),
    .bank_b_in  (bank_b),
    .busy_out   (eng_busy),
    .commit_out (eng_commit),
    .result_out (eng_result)
  );

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
      for (int t = 0; t < T_ENTRIES; t++) tensor_q[t] <= '0;
      status_q    <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (accept && opcode == OP_RESET) begin
        // Also suppresses a commit landing on this edge.
        for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
        for (int t = 0; t < T_ENTRIES; t++) tensor_q[t] <= '0;
        status_q <= '0;
        out_q    <= '0;
      end else begin
        if (eng_commit) begin
          for (int t = 0; t < BANK; t++) tensor_q[t] <= eng_result[t*DATA_WIDTH +: DATA_WIDTH];
        end
        if (accept) begin
          if (is_alu) begin
            if (dest_ok) regs_q[dest[REG_W-1:0]] <= alu_res;
            status_q    <= alu_status;
            out_q       <= alu_res;
            out_valid_q <= 1'b1;
          end
          case (opcode)
            OP_MOV_CPU:   if (dest_ok) regs_q[dest[REG_W-1:0]] <= r_src1;
            OP_TC_TO_CPU: if (dest_ok) regs_q[dest[REG_W-1:0]] <= t_src1_val;
            OP_TC_LOAD:   if (t_dest_ok) tensor_q[t_dest] <= imm_hi;
            OP_CPU_TO_TC: if (t_dest_ok) tensor_q[t_dest] <= r_src1;
            OP_MOV_TC:    if (t_dest_ok) tensor_q[t_dest] <= t_src1_val;
            OP_READ_CPU: begin
              out_q       <= r_src1;
              out_valid_q <= 1'b1;
            end
            OP_READ_TC: begin
              out_q       <= t_src1_val;
              out_valid_q <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign cpu_output_out       = out_q;
  assign cpu_output_valid_out = out_valid_q;
  assign status_out           = status_q;
  assign tensor_busy_out      = eng_busy;

endmodule

// File: tb/tb_param_tensor_cpu.sv
// Directed bench for param_tensor_cpu: a truncating and a saturating DUT see the same stream.
module tb_param_tensor_cpu;
  import param_tensor_cpu_pkg::*;

  logic clock_in   = 1'b0;
  logic reset_n_in = 1'b0;
  always #5 clock_in = ~clock_in;

  param_tensor_cpu_if bus ();
  param_tensor_cpu_if bus_sat ();
  assign bus_sat.instruction_in       = bus.instruction_in;
  assign bus_sat.instruction_valid_in = bus.instruction_valid_in;

  logic [7:0] out0, out1;
  logic       val0, val1, busy0, busy1;
  logic [4:0] stat0, stat1;

  param_tensor_cpu #(.DATA_WIDTH(8), .NUM_REGS(32), .MATRIX_DIM(4), .SATURATE(0)) dut (
    .clock_in             (clock_in),
    .reset_n_in           (reset_n_in),
    .instr_if             (bus),
    .cpu_output_out       (out0),
    .cpu_output_valid_out (val0),
    .status_out           (stat0),
    .tensor_busy_out      (busy0)
  );

  param_tensor_cpu #(.DATA_WIDTH(8), .NUM_REGS(32), .MATRIX_DIM(4), .SATURATE(1)) dut_sat (
    .clock_in             (clock_in),
    .reset_n_in           (reset_n_in),
    .instr_if             (bus_sat),
    .cpu_output_out       (out1),
    .cpu_output_valid_out (val1),
    .status_out           (stat1),
    .tensor_busy_out      (busy1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic issue(input logic [7:0] op, input logic [7:0] d, input logic [7:0] s1,
                       input logic [7:0] s2, output int waited);
    waited = 0;
    @(negedge clock_in);
    bus.instruction_in       = {d, s1, s2, op};
    bus.instruction_valid_in = 1'b1;
    #1;
    while (!bus.instruction_ready_out && waited < 300) begin
      @(negedge clock_in);
      #1;
      waited++;
    end
    n_checks++;
    if (bus.instruction_ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_ready op=%h got ready=%b want 1", op, bus.instruction_ready_out);
    end
    @(posedge clock_in);
    #1;
    bus.instruction_valid_in = 1'b0;
  endtask

  task automatic send(input logic [7:0] op, input logic [7:0] d, input logic [7:0] s1,
                      input logic [7:0] s2);
    int w;
    issue(op, d, s1, s2, w);
  endtask

  task automatic wait_idle();
    int cnt;
    cnt = 0;
    while (busy0 && cnt < 200) begin
      @(posedge clock_in);
      #1;
      cnt++;
    end
    n_checks++;
    if (busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_idle got busy=%b want 0", busy0);
    end
  endtask

  task automatic test_reset();
    bus.instruction_in       = {8'd0, 8'd0, 8'd0, OP_TC_LOAD};
    bus.instruction_valid_in = 1'b0;
    #12;
    n_checks++;
    if ({out0, val0, stat0, busy0, bus.instruction_ready_out} !== {8'h00, 1'b0, 5'b0, 1'b0, 1'b1})
    begin
      n_fail++;
      $display("FAIL reset_state got out=%h v=%b st=%b busy=%b rdy=%b want 00 0 00000 0 1",
               out0, val0, stat0, busy0, bus.instruction_ready_out);
    end
    @(negedge clock_in);
    reset_n_in = 1'b1;
  endtask

  task automatic test_basic();
    send(OP_ADD_IMM, 8'd1, 8'd0, 8'd5);
    send(OP_ADD_IMM, 8'd2, 8'd0, 8'hFD);
    send(OP_ADD, 8'd3, 8'd1, 8'd2);
    n_checks++;
    if (out0 !== 8'h02 || val0 !== 1'b1 || stat0 !== 5'b00100) begin
      n_fail++;
      $display("FAIL basic_add got out=%h v=%b st=%b want 02 1 00100", out0, val0, stat0);
    end
    send(OP_READ_CPU, 8'd0, 8'd3, 8'd0);
    n_checks++;
    if (out0 !== 8'h02 || val0 !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_read got out=%h v=%b want 02 1", out0, val0);
    end
    @(posedge clock_in);
    #1;
    n_checks++;
    if (val0 !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_pulse got v=%b want 0", val0);
    end
  endtask

  task automatic test_overflow();
    send(OP_ADD_IMM, 8'd1, 8'd0, 8'd127);
    send(OP_ADD, 8'd2, 8'd1, 8'd1);
    n_checks++;
    if (out0 !== 8'hFE || stat0 !== 5'b01001) begin
      n_fail++;
      $display("FAIL add_overflow got out=%h st=%b want fe 01001", out0, stat0);
    end
  endtask

  typedef struct {
    logic [7:0] op, d, s1, s2;
    logic       exp_valid;
    logic [7:0] exp_out;
    logic       chk_stat;
    logic [4:0] exp_stat;
  } alu_vec_t;

  task automatic test_alu();
    alu_vec_t v [15];
    v = '{
      '{OP_ADD_IMM,  8'd4,  8'd0,  8'hFD, 1'b1, 8'hFD, 1'b1, 5'b00001},
      '{OP_ADD_IMM,  8'd5,  8'd0,  8'h05, 1'b1, 8'h05, 1'b0, 5'b00000},
      '{OP_MUL,      8'd6,  8'd5,  8'd4,  1'b1, 8'hF1, 1'b1, 5'b00001},
      '{OP_GRT,      8'd7,  8'd4,  8'd5,  1'b1, 8'h00, 1'b1, 5'b10010},
      '{OP_GRT,      8'd7,  8'd5,  8'd4,  1'b1, 8'h01, 1'b1, 5'b00000},
      '{OP_SUB_IMM,  8'd8,  8'd5,  8'h05, 1'b1, 8'h00, 1'b1, 5'b10010},
      '{OP_SUB,      8'd9,  8'd4,  8'd5,  1'b1, 8'hF8, 1'b1, 5'b00001},
      '{OP_SUB,      8'd9,  8'd5,  8'd4,  1'b1, 8'h08, 1'b1, 5'b00100},
      '{OP_ADD_IMM,  8'd10, 8'd0,  8'h40, 1'b1, 8'h40, 1'b0, 5'b00000},
      '{OP_MUL,      8'd11, 8'd10, 8'd10, 1'b1, 8'h00, 1'b1, 5'b11010},
      '{OP_ADD_IMM,  8'd40, 8'd0,  8'h09, 1'b1, 8'h09, 1'b0, 5'b00000},
      '{OP_READ_CPU, 8'd0,  8'd40, 8'd0,  1'b1, 8'h00, 1'b0, 5'b00000},
      '{OP_MOV_CPU,  8'd12, 8'd5,  8'd0,  1'b0, 8'h00, 1'b0, 5'b00000},
      '{OP_READ_CPU, 8'd0,  8'd12, 8'd0,  1'b1, 8'h05, 1'b0, 5'b00000},
      '{OP_EQL,      8'd13, 8'd12, 8'd5,  1'b1, 8'h01, 1'b1, 5'b00000}
    };
    for (int i = 0; i < 15; i++) begin
      send(v[i].op, v[i].d, v[i].s1, v[i].s2);
      n_checks++;
      if (val0 !== v[i].exp_valid || (v[i].exp_valid && out0 !== v[i].exp_out) ||
          (v[i].chk_stat && stat0 !== v[i].exp_stat)) begin
        n_fail++;
        $display("FAIL alu_vec%0d op=%h got out=%h v=%b st=%b want out=%h v=%b st=%b",
                 i, v[i].op, out0, val0, stat0, v[i].exp_out, v[i].exp_valid, v[i].exp_stat);
      end
    end
  endtask

  task automatic test_identity();
    int cnt;
    for (int a = 0; a < 16; a++) send(OP_TC_LOAD, 8'(a), (a / 4 == a % 4) ? 8'd1 : 8'd0, 8'd0);
    for (int a = 0; a < 16; a++) send(OP_TC_LOAD, 8'(16 + a), 8'(a + 1), 8'd0);
    send(OP_TC_OPERATE, 8'd0, 8'd0, 8'd0);
    cnt = 0;
    while (busy0 && cnt < 200) begin
      cnt++;
      @(posedge clock_in);
      #1;
    end
    n_checks++;
    if (cnt != 65) begin
      n_fail++;
      $display("FAIL busy_cycles got %0d want 65", cnt);
    end
    for (int a = 0; a < 32; a++) begin
      send(OP_READ_TC, 8'd0, 8'(a), 8'd0);
      n_checks++;
      if (out0 !== 8'((a % 16) + 1) || val0 !== 1'b1) begin
        n_fail++;
        $display("FAIL identity_tc%0d got %h want %h", a, out0, 8'((a % 16) + 1));
      end
    end
  endtask

  task automatic test_concurrent();
    int w;
    send(OP_TC_OPERATE, 8'd0, 8'd0, 8'd0);
    send(OP_ADD_IMM, 8'd14, 8'd0, 8'd7);
    n_checks++;
    if (out0 !== 8'h07 || val0 !== 1'b1 || busy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL cpu_during_run got out=%h v=%b busy=%b want 07 1 1", out0, val0, busy0);
    end
    issue(OP_TC_LOAD, 8'd16, 8'd9, 8'd0, w);
    n_checks++;
    if (w != 64 || busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL tc_stall got wait=%0d busy=%b want 64 0", w, busy0);
    end
    send(OP_READ_TC, 8'd0, 8'd16, 8'd0);
    n_checks++;
    if (out0 !== 8'h09) begin
      n_fail++;
      $display("FAIL stalled_load got %h want 09", out0);
    end
  endtask

  task automatic test_saturate();
    for (int a = 0; a < 32; a++) send(OP_TC_LOAD, 8'(a), 8'd100, 8'd0);
    send(OP_TC_OPERATE, 8'd0, 8'd0, 8'd0);
    wait_idle();
    for (int a = 0; a < 16; a++) begin
      send(OP_READ_TC, 8'd0, 8'(a), 8'd0);
      n_checks++;
      if (out0 !== 8'h40 || out1 !== 8'h7F || val1 !== 1'b1) begin
        n_fail++;
        $display("FAIL sat_c%0d got trunc=%h sat=%h want 40 7f", a, out0, out1);
      end
    end
    send(OP_READ_TC, 8'd0, 8'd20, 8'd0);
    n_checks++;
    if (out0 !== 8'd100 || out1 !== 8'd100) begin
      n_fail++;
      $display("FAIL bank_b_kept got %h %h want 64 64", out0, out1);
    end
  endtask

  task automatic test_reset_op();
    send(OP_TC_OPERATE, 8'd0, 8'd0, 8'd0);
    repeat (10) @(posedge clock_in);
    send(OP_ADD_IMM, 8'd1, 8'd0, 8'hFF);
    n_checks++;
    if (out0 !== 8'hFF || stat0 !== 5'b10001) begin
      n_fail++;
      $display("FAIL pre_reset got out=%h st=%b want ff 10001", out0, stat0);
    end
    send(OP_RESET, 8'd0, 8'd0, 8'd0);
    n_checks++;
    if (busy0 !== 1'b0 || stat0 !== 5'b0 || out0 !== 8'h00 || val0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_op got busy=%b st=%b out=%h v=%b want 0 00000 00 0",
               busy0, stat0, out0, val0);
    end
    for (int a = 0; a < 32; a += 16) begin
      send(OP_READ_TC, 8'd0, 8'(a), 8'd0);
      n_checks++;
      if (out0 !== 8'h00 || val0 !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_op_tc%0d got %h want 00", a, out0);
      end
    end
    send(OP_READ_CPU, 8'd0, 8'd1, 8'd0);
    n_checks++;
    if (out0 !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_op_reg got %h want 00", out0);
    end
  endtask

  task automatic test_async_reset();
    send(OP_TC_LOAD, 8'd0, 8'd3, 8'd0);
    send(OP_TC_OPERATE, 8'd0, 8'd0, 8'd0);
    repeat (5) @(posedge clock_in);
    send(OP_ADD_IMM, 8'd1, 8'd0, 8'hFF);
    @(negedge clock_in);
    bus.instruction_in = {8'd0, 8'd0, 8'd0, OP_TC_LOAD};
    #1;
    reset_n_in = 1'b0;
    #1;
    n_checks++;
    if ({out0, val0, stat0, busy0, bus.instruction_ready_out} !== {8'h00, 1'b0, 5'b0, 1'b0, 1'b1})
    begin
      n_fail++;
      $display("FAIL async_reset got out=%h v=%b st=%b busy=%b rdy=%b want 00 0 00000 0 1",
               out0, val0, stat0, busy0, bus.instruction_ready_out);
    end
    @(negedge clock_in);
    reset_n_in = 1'b1;
    send(OP_READ_CPU, 8'd0, 8'd1, 8'd0);
    n_checks++;
    if (out0 !== 8'h00 || val0 !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset_reg got %h want 00", out0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_alu();
    test_identity();
    test_concurrent();
    test_saturate();
    test_reset_op();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired after %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/param_tensor_cpu.md
# param_tensor_cpu

Parametrised successor of the single-cycle 8-bit CPU with its attached 4x4 tensor core. It generalises data width, register count and matrix dimension, adds a valid/ready instruction handshake, and replaces the combinational tensor core with a sequential one-MAC-per-cycle engine. CPU-only instructions keep issuing while the engine runs. It is the top-level compute block, fed 32-bit instructions by the test harness or the instruction sequencer.

## Interface
- DATA_WIDTH, 8: signed datapath width, 4..16.
- NUM_REGS, 32: CPU register count, ≤ 256. Address is instruction[31:24]; out-of-range addresses read 0 and ignore writes.
- MATRIX_DIM, 4: N, 2..8. Tensor file holds 2·N·N entries: bank A at 0..N²-1, bank B at N²..2N²-1, row-major. Tensor address is the low TADDR_W = clog2(2N²) bits of the field.
- SATURATE, 0: 0 truncates MAC results to DATA_WIDTH; 1 clamps them to the signed range.
- clock_in  input  1: single clock, rising edge.
- reset_n_in  input  1: asynchronous, active-low reset.
- instruction_in  input  32: [31:24] dest/tensor-dest, [23:16] src1/imm8, [15:8] src2/imm8, [7:0] opcode.
- instruction_valid_in  input  1: instruction_in is presented.
- instruction_ready_out  output  1: the block can accept instruction_in this cycle.
- cpu_output_out  output  DATA_WIDTH: registered result.
- cpu_output_valid_out  output  1: one-cycle pulse qualifying cpu_output_out.
- status_out  output  5: {parity, overflow, carry, zero, sign}.
- tensor_busy_out  output  1: MAC engine not IDLE.

## Operation
- Opcode encodings are unchanged from the previous generation: ADD 0x00, SUB 0x01, MUL 0x02, EQL 0x03, GRT 0x04, TC_OPERATE 0x05, TC_LOAD 0x06, CPU_TO_TC 0x07, NOP 0x08, ADD_IMM 0x09, SUB_IMM 0x0A, MOV_CPU 0x0B, MOV_TC 0x0C, RESET 0x0D, TC_TO_CPU 0x0E, READ_CPU 0x0F, READ_TC 0x10. Unknown opcodes act as NOP.
- An instruction is accepted on a rising edge with valid && ready.
- Tensor-class instructions are opcodes 0x05, 0x06, 0x07, 0x0C, 0x0E and 0x10. While tensor_busy_out is high, ready is low for these.
- Ready is high for all other opcodes, and always high when the engine is idle.
- ALU ops:
  - ADD, SUB: wrap modulo 2^DATA_WIDTH.
  - MUL: low DATA_WIDTH bits of the signed product.
  - EQL, GRT: return 1 or 0; comparisons are signed.
  - Immediates come from [15:8], sign-extended.
- ALU ops write dest and update status.
  - Carry is the unsigned carry for ADD and the unsigned borrow for SUB; it is 0 for the other ops.
  - Overflow is signed overflow, including MUL truncation.
  - Zero and sign follow the result; parity is 1 when the result has an even number of ones.
- MOV_CPU copies src1 to dest. TC_TO_CPU copies tensor[src1] to dest. Neither touches status.
- TC_LOAD writes tensor[dest] with sign-extended imm [23:16]. CPU_TO_TC writes tensor[dest] with reg[src1]. MOV_TC copies tensor[src1] to tensor[dest].
- cpu_output_out produces results as follows:
  - ALU ops: the result.
  - READ_CPU: reg[src1].
  - READ_TC: tensor[src1].
  - Every other opcode leaves cpu_output_out unchanged, and valid stays low.
- TC_OPERATE computes C = A × B and writes C into bank A; bank B is preserved. Engine states:
  - IDLE → RUN on accept; i, j, k and the accumulator clear.
  - RUN: one MAC per cycle, acc += A[i][k]·B[k][j], with acc width 2·DATA_WIDTH + clog2(N). When k = N-1, C[i][j] is stored (truncated or saturated) into an internal result buffer. The engine walks j, then i.
  - RUN → COMMIT after N³ MACs. COMMIT writes the whole buffer into bank A in one cycle, then returns to IDLE.
  - The engine reads A and B from the tensor file live. This is safe because tensor writes are stalled while busy.
- RESET opcode is accepted even when busy. It zeroes both register files, status and the output register, and forces the engine to IDLE with no commit.

## Timing
- Async reset sets all registers, files, status_out, cpu_output_out, cpu_output_valid_out and tensor_busy_out to 0, puts the engine in IDLE, and drives instruction_ready_out to 1.
- Register-file and tensor writes take effect at the accept edge. A following instruction reads the new value; there is no read-after-write hazard.
- cpu_output_valid_out pulses the cycle after accept, with the result held in cpu_output_out.
- TC_OPERATE accepted at edge t:
  - tensor_busy_out is high from t+1 through t+N³+1.
  - Bank A is updated at edge t+N³+1.
  - Tensor-class ready returns at t+N³+2.
  - For N=4 that is 65 busy cycles.
- If a CPU-only write and the engine commit happen on the same edge, both complete; they target disjoint storage.
- If RESET coincides with COMMIT, RESET wins and bank A is zeroed.

## Structure
- param_tensor_cpu_pkg holds the opcode localparams, the engine state enum {IDLE, RUN, COMMIT}, and a tensor_class(opcode) function.
- One sub-module, tensor_mac_engine, contains the FSM, the index counters, the accumulator, saturation and the result buffer. It takes the A/B bank read vectors and a start input, and exposes commit_out plus the buffer.
- Register files stay inline in the top level.

## Test plan
- Reset, then ADD_IMM r1=r0+5, then ADD_IMM r2=r0+-3, then ADD r3=r1+r2, then READ_CPU r3 → output 2. After the ADD, status carry=1 and zero=0.
- With DATA_WIDTH=8: r1=127, then ADD r2=r1+r1 → output -2, overflow=1 and sign=1.
- Load A = identity and B[k][j] = 4k+j+1, then TC_OPERATE → busy for exactly 65 cycles. After that, READ_TC of 0..15 returns 1..16 and READ_TC of 16..31 still returns B.
- During TC_OPERATE, issue ADD_IMM (accepted, with output the next cycle) and TC_LOAD (ready=0 until busy falls, then accepted).
- With SATURATE=1, A and B all 100 and N=4 → every C entry is 127. With SATURATE=0 the entries are (40000 mod 256) sign-interpreted, i.e. 64.
- Issue RESET opcode mid-RUN → busy falls the next cycle, bank A reads 0, status reads 0. Assert reset_n_in mid-RUN → all outputs are 0 immediately.
